// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared counter constants and max-value helper
package counter_pkg;

    localparam int COUNTER_DEFAULT_WIDTH = 8;

    // All-ones value for widths up to 64; callers slice off the low bits they need.
    function automatic logic [63:0] counter_max(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/up_counter_if.sv
// rtl/up_counter_if.sv - control/status bundle between a counter and its user
interface up_counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_DEFAULT_WIDTH
);
    logic             clear;
    logic             count;
    logic [WIDTH-1:0] Q;
    logic             tc;

    modport master (output clear, output count, input Q, input tc);
    modport slave  (input clear, input count, output Q, output tc);
endinterface

// File: rtl/up_counter.sv
// rtl/up_counter.sv - binary up-counter with enable and sync clear; COUNTER_SATURATE_EN selects saturation
module up_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_DEFAULT_WIDTH
) (
    input logic         clock,
    input logic         reset_n,
    up_counter_if.slave bus
);

    localparam logic [63:0]      MAX_FULL = counter_max(WIDTH);
    localparam logic [WIDTH-1:0] MAX_VAL  = MAX_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] q;

    // clear outranks count; reset is the only asynchronous path
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (bus.clear) begin
            q <= '0;
        end else if (bus.count) begin
`ifdef COUNTER_SATURATE_EN
            if (q != MAX_VAL) begin
                q <= q + 1'b1;
            end
`else
            q <= q + 1'b1;
`endif
        end
    end

    assign bus.Q  = q;
    assign bus.tc = (q == MAX_VAL);

endmodule

// File: tb/tb_up_counter.sv
// tb/tb_up_counter.sv - directed self-checking bench for up_counter (WIDTH=8)
module tb_up_counter;

    localparam int WIDTH = 8;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    up_counter_if #(.WIDTH(WIDTH)) bus ();

    up_counter #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_value(input int v);
        bus.clear = 1'b1;
        bus.count = 1'b0;
        step();
        bus.clear = 1'b0;
        bus.count = 1'b1;
        for (int i = 0; i < v; i++) step();
        bus.count = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.clear = 1'b0;
        bus.count = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.Q !== 8'd0 || bus.tc !== 1'b0) begin
                errors++;
                $display("FAIL reset cycle %0d: Q=%0d tc=%b, expected Q=0 tc=0", i, bus.Q, bus.tc);
            end
        end
        bus.count = 1'b0;
        reset_n   = 1'b1;
    endtask

    task automatic test_clear_count();
        bus.clear = 1'b1;
        step();
        checks++;
        if (bus.Q !== 8'd0) begin
            errors++;
            $display("FAIL clear: Q=%0d, expected 0", bus.Q);
        end
        bus.clear = 1'b0;
        bus.count = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            step();
            checks++;
            if (bus.Q !== 8'(i) || bus.tc !== 1'b0) begin
                errors++;
                $display("FAIL count edge %0d: Q=%0d tc=%b, expected Q=%0d tc=0", i, bus.Q, bus.tc, i);
            end
        end
        bus.count = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.Q !== 8'd200) begin
                errors++;
                $display("FAIL hold %0d: Q=%0d, expected 200", i, bus.Q);
            end
        end
    endtask

    task automatic test_priority();
        load_value(37);
        checks++;
        if (bus.Q !== 8'd37) begin
            errors++;
            $display("FAIL priority preload: Q=%0d, expected 37", bus.Q);
        end
        bus.clear = 1'b1;
        bus.count = 1'b1;
        step();
        checks++;
        if (bus.Q !== 8'd0) begin
            errors++;
            $display("FAIL priority clear+count: Q=%0d, expected 0", bus.Q);
        end
        bus.clear = 1'b0;
        bus.count = 1'b0;
    endtask

`ifndef COUNTER_SATURATE_EN
    task automatic test_wrap();
        int exp_q;
        load_value(250);
        checks++;
        if (bus.Q !== 8'd250 || bus.tc !== 1'b0) begin
            errors++;
            $display("FAIL wrap preload: Q=%0d tc=%b, expected Q=250 tc=0", bus.Q, bus.tc);
        end
        bus.count = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_q = (250 + k) % 256;
            checks++;
            if (bus.Q !== 8'(exp_q) || bus.tc !== (exp_q == 255)) begin
                errors++;
                $display("FAIL wrap edge %0d: Q=%0d tc=%b, expected Q=%0d tc=%b",
                         k, bus.Q, bus.tc, exp_q, (exp_q == 255));
            end
        end
        bus.count = 1'b0;
    endtask
`else
    task automatic test_saturate();
        int exp_q;
        load_value(250);
        bus.count = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_q = (250 + k > 255) ? 255 : 250 + k;
            checks++;
            if (bus.Q !== 8'(exp_q) || bus.tc !== (exp_q == 255)) begin
                errors++;
                $display("FAIL saturate edge %0d: Q=%0d tc=%b, expected Q=%0d tc=%b",
                         k, bus.Q, bus.tc, exp_q, (exp_q == 255));
            end
        end
        bus.count = 1'b0;
        bus.clear = 1'b1;
        step();
        checks++;
        if (bus.Q !== 8'd0 || bus.tc !== 1'b0) begin
            errors++;
            $display("FAIL saturate clear: Q=%0d tc=%b, expected Q=0 tc=0", bus.Q, bus.tc);
        end
        bus.clear = 1'b0;
    endtask
`endif

    task automatic test_async_reset();
        load_value(120);
        checks++;
        if (bus.Q !== 8'd120) begin
            errors++;
            $display("FAIL async preload: Q=%0d, expected 120", bus.Q);
        end
        bus.count = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.Q !== 8'd0 || bus.tc !== 1'b0) begin
            errors++;
            $display("FAIL async reset between edges: Q=%0d tc=%b, expected Q=0 tc=0", bus.Q, bus.tc);
        end
        @(negedge clock);
        reset_n = 1'b1;
        step();
        checks++;
        if (bus.Q !== 8'd1) begin
            errors++;
            $display("FAIL resume first edge: Q=%0d, expected 1", bus.Q);
        end
        step();
        checks++;
        if (bus.Q !== 8'd2) begin
            errors++;
            $display("FAIL resume second edge: Q=%0d, expected 2", bus.Q);
        end
        bus.count = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        bus.clear = 1'b0;
        bus.count = 1'b0;
        test_reset();
        test_clear_count();
        test_priority();
`ifndef COUNTER_SATURATE_EN
        test_wrap();
`else
        test_saturate();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
